// File: rtl/gf163_mult_arbiter.sv
// Purpose: round-robin share of one GF(2^163) multiplier among NREQ requesters, with a watchdog.
// Latency: grant 1 cycle after req; rsp_valid 1 cycle after mul_done; RELEASE+IDLE keep start low >=2 cycles.
// Backpressure: req is a held level; only IDLE samples it, and dropping the granted req aborts the operation.
module gf163_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int M       = 163,
  parameter int TIMEOUT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*M-1:0]   op_a,
  input  logic [NREQ*M-1:0]   op_b,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [M-1:0]        rsp_data,
  output logic                err,
  output logic                busy,
  output logic                mul_start,
  output logic [M-1:0]        mul_a,
  output logic [M-1:0]        mul_b,
  input  logic [M-1:0]        mul_z,
  input  logic                mul_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, RELEASE} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   gidx_q;
  logic [WW-1:0]   wd_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [M-1:0]    rsp_data_q;
  logic            err_q;
  logic            mul_start_q;
  logic [M-1:0]    mul_a_q;
  logic [M-1:0]    mul_b_q;

  // next-grant candidates computed from the current rr pointer
  logic            found_d;
  logic [IW-1:0]   gidx_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   scan_idx;
  logic [M-1:0]    a_arr [NREQ];
  logic [M-1:0]    b_arr [NREQ];

  // unpack the flat operand buses so the winner can be selected by index
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = op_a[i*M +: M];
      b_arr[i] = op_b[i*M +: M];
    end
  end

  // round-robin search: first set req bit starting at rr_q, wrapping around
  always_comb begin
    found_d  = 1'b0;
    gidx_d   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IW'((int'(rr_q) + k) % NREQ);
      if (!found_d && req[scan_idx]) begin
        found_d = 1'b1;
        gidx_d  = scan_idx;
      end
    end
    gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << gidx_d;
  end

  // control FSM; every output is a register so the multiplier sees glitch-free start/operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gidx_q      <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gidx_q      <= gidx_d;
            gnt_q       <= gnt_d;
            mul_a_q     <= a_arr[gidx_d];
            mul_b_q     <= b_arr[gidx_d];
            mul_start_q <= 1'b1;
            wd_q        <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q <= wd_q + WW'(1);
          // completion wins over abandonment and timeout in the same cycle
          if (mul_done) begin
            rsp_data_q  <= mul_z;
            rsp_valid_q <= gnt_q;
            mul_start_q <= 1'b0;
            state_q     <= RESP;
          end else if (!req[gidx_q]) begin
            mul_start_q <= 1'b0;
            gnt_q       <= '0;
            state_q     <= RELEASE;
          end else if (wd_q == WD_LAST) begin
            err_q       <= 1'b1;
            mul_start_q <= 1'b0;
            gnt_q       <= '0;
            state_q     <= RELEASE;
          end
        end
        RESP: begin
          gnt_q   <= '0;
          state_q <= RELEASE;
        end
        RELEASE: begin
          rr_q    <= (gidx_q == IDX_LAST) ? '0 : gidx_q + IW'(1);
          wd_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_gf163_mult_arbiter.sv
// Bench for gf163_mult_arbiter: behavioural multiplier stub plus a reference arbitration model.
// Expected products come from a schoolbook polynomial multiply followed by reduction mod f.
// Directed scenarios followed by randomized request masks and operands.
module tb_gf163_mult_arbiter;
  localparam int NREQ    = 4;
  localparam int M       = 163;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*M-1:0] op_a = '0;
  logic [NREQ*M-1:0] op_b = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [M-1:0]      rsp_data;
  logic              err;
  logic              busy;
  logic              mul_start;
  logic [M-1:0]      mul_a;
  logic [M-1:0]      mul_b;
  logic [M-1:0]      mul_z = '0;
  logic              mul_done = 1'b0;

  gf163_mult_arbiter #(.NREQ(NREQ), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // reference GF(2^163) product: full polynomial multiply, then reduce from the top
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] f;
    p = '0;
    f = '0;
    f[M] = 1'b1;
    f[7:0] = 8'hC9;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (f << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rnd_f();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  // multiplier stub: done pulse `lat` cycles after start rises, or never when hung
  int lat = 167;
  bit hang = 1'b0;
  bit stray = 1'b0;
  int scnt = 0;
  always @(negedge clk) begin
    if (mul_start) begin
      scnt = scnt + 1;
      if (!hang && scnt == lat) begin
        mul_done = 1'b1;
        mul_z    = gf_mul(mul_a, mul_b);
      end else begin
        mul_done = 1'b0;
        mul_z    = rnd_f();
      end
    end else begin
      scnt     = 0;
      mul_done = stray;
      mul_z    = rnd_f();
    end
  end

  // passive monitor: event counts and timestamps, read by the main sequence
  int cyc = 0;
  int start_rise_cyc = 0;
  int err_cyc = 0;
  int err_cnt = 0;
  int rsp_cnt = 0;
  int inv_bad = 0;
  int low_run = 0;
  int min_low = 1000000;
  bit seen_op = 1'b0;
  bit prev_start = 1'b0;
  int gnt_cnt [NREQ];
  int rv_cnt  [NREQ];
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      gnt_cnt[i] = 0;
      rv_cnt[i]  = 0;
    end
  end
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mul_start && !prev_start) begin
      start_rise_cyc = cyc;
      if (seen_op && low_run < min_low) min_low = low_run;
      seen_op = 1'b1;
    end
    low_run = mul_start ? 0 : low_run + 1;
    prev_start = mul_start;
    if (err === 1'b1) begin
      err_cyc = cyc;
      err_cnt = err_cnt + 1;
    end
    if (rsp_valid !== '0) begin
      rsp_cnt = rsp_cnt + 1;
      if (rsp_valid !== gnt) inv_bad = inv_bad + 1;
    end
    if ($countones(gnt) > 1) inv_bad = inv_bad + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] === 1'b1) gnt_cnt[i] = gnt_cnt[i] + 1;
      if (rsp_valid[i] === 1'b1) rv_cnt[i] = rv_cnt[i] + 1;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int p, input logic [M-1:0] a, input logic [M-1:0] b);
    op_a[p*M +: M] = a;
    op_b[p*M +: M] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, output int p);
    bit ok;
    ok = 1'b0;
    p = -1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (gnt !== '0) begin
        ok = 1'b1;
        for (int j = 0; j < NREQ; j++) if (gnt[j] === 1'b1) p = j;
      end
    end
    chk_i({tag, "_gnt_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, output int p, output logic [M-1:0] d);
    bit ok;
    ok = 1'b0;
    p = -1;
    d = '0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (rsp_valid !== '0) begin
        ok = 1'b1;
        d = rsp_data;
        for (int j = 0; j < NREQ; j++) if (rsp_valid[j] === 1'b1) p = j;
      end
    end
    chk_i({tag, "_rsp_timeout"}, 32'(ok), 32'd1);
  endtask

  int p, rp, mptr, exp_p, srise, snap_rsp, snap_err, gmask, rmask;
  int g0 [NREQ];
  int r0 [NREQ];
  logic [M-1:0] d, exp_d, last_d;
  bit ok;

  initial begin
    // reset state
    tick();
    chk_i("rst_gnt", 32'(gnt), 32'd0);
    chk_i("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_i("rst_err", 32'(err), 32'd0);
    chk_i("rst_busy", 32'(busy), 32'd0);
    chk_i("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    chk("rst_rsp_data", rsp_data, '0);
    rst = 1'b0;
    tick();

    // single operation 1*1, registered grant
    set_op(0, 163'd1, 163'd1);
    req = 4'b0001;
    tick();
    chk_i("single_gnt_next_cycle", 32'(gnt), 32'd1);
    chk_i("single_start", 32'(mul_start), 32'd1);
    chk_i("single_busy", 32'(busy), 32'd1);
    chk("single_mul_a", mul_a, 163'd1);
    wait_rsp("single", rp, d);
    chk_i("single_rsp_port", rp, 0);
    chk("single_rsp_data", d, 163'd1);
    chk_i("single_start_low_resp", 32'(mul_start), 32'd0);
    req = '0;
    tick();
    chk_i("single_gnt_release", 32'(gnt), 32'd0);
    chk_i("single_start_low_release", 32'(mul_start), 32'd0);
    tick();
    chk_i("single_idle_busy", 32'(busy), 32'd0);

    // reduction: x * x^162 = x^7 + x^6 + x^3 + 1
    for (int i = 0; i < NREQ; i++) begin
      g0[i] = gnt_cnt[i];
      r0[i] = rv_cnt[i];
    end
    set_op(2, 163'h2, 163'd1 << 162);
    req = 4'b0100;
    wait_gnt("reduce", p);
    chk_i("reduce_gnt_port", p, 2);
    wait_rsp("reduce", rp, d);
    chk_i("reduce_rsp_port", rp, 2);
    chk("reduce_rsp_data", d, 163'hC9);
    last_d = d;
    req = '0;
    tick();
    tick();
    gmask = 0;
    rmask = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_cnt[i] != g0[i]) gmask = gmask | (1 << i);
      if (rv_cnt[i] != r0[i]) rmask = rmask | (1 << i);
    end
    chk_i("reduce_only_gnt2", gmask, 32'h4);
    chk_i("reduce_only_rv2", rmask, 32'h4);
    chk_i("reduce_one_rsp", rv_cnt[2] - r0[2], 1);

    // round-robin from pointer 0 with all held, then random masks
    do_reset();
    mptr = 0;
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_f(), rnd_f());
    req = 4'b1111;
    for (int n = 0; n < 17; n++) begin
      exp_p = -1;
      for (int k = 0; k < NREQ; k++)
        if (exp_p < 0 && req[(mptr + k) % NREQ]) exp_p = (mptr + k) % NREQ;
      lat = $urandom_range(2, 40);
      wait_gnt("rr", p);
      chk_i("rr_grant_order", p, exp_p);
      if (p >= 0) begin
        exp_d = gf_mul(op_a[p*M +: M], op_b[p*M +: M]);
        // operands changed after grant must not affect this product
        set_op(p, rnd_f(), rnd_f());
      end else begin
        exp_d = '0;
      end
      wait_rsp("rr", rp, d);
      chk_i("rr_rsp_port", rp, p);
      chk("rr_rsp_data", d, exp_d);
      if (p >= 0) mptr = (p + 1) % NREQ;
      if (n == 16) req = '0;
      else if (n >= 4) req = 4'($urandom_range(1, 15));
      tick();
    end
    tick();
    chk_i("rr_idle_after", 32'(busy), 32'd0);

    // abort: port 1 drops req 50 cycles into the operation
    do_reset();
    lat = 167;
    set_op(1, rnd_f(), rnd_f());
    set_op(2, rnd_f(), rnd_f());
    req = 4'b0110;
    wait_gnt("abort", p);
    chk_i("abort_first_port", p, 1);
    for (int i = 0; i < 50; i++) tick();
    chk_i("abort_start_before_drop", 32'(mul_start), 32'd1);
    snap_rsp = rsp_cnt;
    req[1] = 1'b0;
    tick();
    chk_i("abort_start_falls", 32'(mul_start), 32'd0);
    chk_i("abort_gnt_falls", 32'(gnt), 32'd0);
    exp_d = gf_mul(op_a[2*M +: M], op_b[2*M +: M]);
    wait_gnt("abort_next", p);
    chk_i("abort_next_port", p, 2);
    wait_rsp("abort_next", rp, d);
    chk_i("abort_next_rsp_port", rp, 2);
    chk("abort_next_data", d, exp_d);
    chk_i("abort_no_rsp_port1", rsp_cnt - snap_rsp, 1);
    last_d = d;
    req = '0;
    tick();

    // watchdog: stub never completes
    hang = 1'b1;
    snap_err = err_cnt;
    snap_rsp = rsp_cnt;
    set_op(0, rnd_f(), rnd_f());
    req = 4'b0001;
    wait_gnt("wd", p);
    chk_i("wd_port", p, 0);
    srise = start_rise_cyc;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (err === 1'b1) ok = 1'b1;
    end
    chk_i("wd_err_seen", 32'(ok), 32'd1);
    chk_i("wd_err_latency", err_cyc - srise, TIMEOUT);
    chk_i("wd_start_low", 32'(mul_start), 32'd0);
    chk_i("wd_gnt_low", 32'(gnt), 32'd0);
    req = '0;
    tick();
    chk_i("wd_err_one_pulse", 32'(err), 32'd0);
    tick();
    chk_i("wd_busy_low", 32'(busy), 32'd0);
    chk_i("wd_err_count", err_cnt - snap_err, 1);
    chk_i("wd_no_rsp", rsp_cnt - snap_rsp, 0);
    hang = 1'b0;

    // stray mul_done while idle is ignored
    snap_rsp = rsp_cnt;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    tick();
    chk_i("stray_no_rsp", rsp_cnt - snap_rsp, 0);
    chk_i("stray_busy", 32'(busy), 32'd0);
    chk("stray_rsp_data_kept", rsp_data, last_d);

    // async reset 80 cycles into an operation
    lat = 1000;
    set_op(1, rnd_f(), rnd_f());
    req = 4'b0010;
    wait_gnt("midrst", p);
    chk_i("midrst_port", p, 1);
    for (int i = 0; i < 80; i++) tick();
    snap_rsp = rsp_cnt;
    snap_err = err_cnt;
    rst = 1'b1;
    #1;
    chk_i("midrst_start_low", 32'(mul_start), 32'd0);
    chk_i("midrst_gnt_low", 32'(gnt), 32'd0);
    chk_i("midrst_busy_low", 32'(busy), 32'd0);
    chk("midrst_mul_a", mul_a, '0);
    set_op(3, rnd_f(), rnd_f());
    req = 4'b1000;
    tick();
    tick();
    lat = 167;
    rst = 1'b0;
    exp_d = gf_mul(op_a[3*M +: M], op_b[3*M +: M]);
    wait_gnt("midrst_after", p);
    chk_i("midrst_after_port", p, 3);
    wait_rsp("midrst_after", rp, d);
    chk_i("midrst_after_rsp_port", rp, 3);
    chk("midrst_after_data", d, exp_d);
    chk_i("midrst_rsp_count", rsp_cnt - snap_rsp, 1);
    chk_i("midrst_err_count", err_cnt - snap_err, 0);
    req = '0;
    tick();
    tick();

    // global properties gathered by the monitor
    chk_i("inv_gnt_rsp_consistent", inv_bad, 0);
    chk_i("start_low_gap_ge2", 32'(min_low >= 2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gf163_mult_arbiter.md
Name: gf163_mult_arbiter

Overview:
- Shares one GF(2^163) interleaved multiplier (mod f = x^163+x^7+x^6+x^3+1) between NREQ requesters, e.g. point-add and point-double units of the ECC core.
- Arbitrates round-robin, latches the winner's operands and sequences the multiplier's start/done handshake.
- Returns the product only to the granted requester; a watchdog aborts hung operations.

Parameters:
- NREQ, 4, number of requesters (2..8)
- M, 163, field width in bits
- TIMEOUT, 200, max cycles from mul_start rise to mul_done before abort (must exceed multiplier latency, ~167)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level; held high until rsp_valid or abandoned
- op_a  in  NREQ*M  operand A, requester i at bits [i*M +: M]
- op_b  in  NREQ*M  operand B, same packing
- gnt  out  NREQ  one-hot grant, high while requester's operation is in flight
- rsp_valid  out  NREQ  one-cycle pulse to the granted requester when rsp_data is valid
- rsp_data  out  M  product, valid only during a rsp_valid pulse
- err  out  1  one-cycle pulse on watchdog abort
- busy  out  1  high in any state except IDLE
- mul_start  out  1  level start to multiplier
- mul_a  out  M  registered operand A to multiplier
- mul_b  out  M  registered operand B to multiplier
- mul_z  in  M  multiplier result
- mul_done  in  1  multiplier done pulse (1 cycle)

Behaviour:
- Reset (async): state=IDLE; gnt, rsp_valid, err, mul_start = 0; mul_a, mul_b, rsp_data = 0; rr pointer = 0; watchdog = 0.
- States: IDLE, ISSUE, RESP, RELEASE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr pointer upward with wrap.
  - Set gnt to that one-hot, latch its op_a/op_b into mul_a/mul_b, go to ISSUE.
  - Grant is registered: gnt is high the cycle after req is sampled.
- ISSUE:
  - mul_start=1, held every cycle; watchdog increments each cycle.
  - mul_done=1: capture mul_z into rsp_data, go to RESP. This takes priority over req drop or timeout in the same cycle.
  - Else if req[granted] dropped: abort, no response, go to RELEASE.
  - Else if watchdog reaches TIMEOUT: pulse err, go to RELEASE.
- RESP (1 cycle): rsp_valid[granted]=1, mul_start=0; go to RELEASE.
- RELEASE (1 cycle):
  - mul_start=0 and gnt=0.
  - rr pointer = granted index + 1 mod NREQ.
  - Watchdog cleared; go to IDLE.
  - Guarantees start is low for at least 2 cycles between operations so the multiplier returns to its idle state.
- mul_a/mul_b stay stable from grant through RELEASE. Requester operand changes after grant are ignored.
- gnt stays high through ISSUE and RESP; gnt and rsp_valid always identify the same requester.
- Fairness: a continuously requesting port waits at most NREQ-1 operations.
- req rising during ISSUE/RESP/RELEASE is sampled only in IDLE; no queueing beyond the req level itself.
- A mul_done arriving outside ISSUE is ignored.
- Async reset mid-operation forces mul_start low immediately. No rsp_valid or err is generated for the lost operation.

Test Plan:
- Single op: req[0]=1, op_a=1, op_b=1 -> one rsp_valid[0] pulse, rsp_data=1; gnt back to 0; mul_start low ≥2 cycles afterwards.
- Reduction: req[2]=1, A=0x2 (x), B=1<<162 -> rsp_data=0xC9 (x^7+x^6+x^3+1); only gnt[2]/rsp_valid[2] ever high.
- Round-robin: req=4'b1111 held, distinct operands per port -> grant order 0,1,2,3,0; each rsp_data matches that port's reference product.
- Abort: req[1] dropped 50 cycles after mul_start -> no rsp_valid; mul_start falls next cycle; next grant goes to port 2 if requesting.
- Watchdog: stub multiplier never asserts mul_done, TIMEOUT=200 -> err pulses exactly 200 cycles after mul_start rise; busy returns low 2 cycles later.
- Reset mid-op: assert rst 80 cycles into ISSUE -> mul_start, gnt, busy low immediately; after release, req[3] gets served first (rr pointer=0, only port 3 requesting) with a correct product.
